// File: rtl/peri_arb_pkg.sv
// Shared types and constants for the peripheral register-bus arbiter.
package peri_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_st_e;

  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;
  localparam int          TO_W      = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_gnt, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  logic [IW-1:0] cand [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(last_gnt) + gi + 1) % NREQ);
    end
  endgenerate

  // Scan from the farthest candidate inwards so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        gnt_idx = cand[k];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peri_reg_arb.sv
// Shares the peripheral register bus between NREQ masters: round-robin grant,
// one transaction in flight, ack timeout terminating with an error response.
module peri_reg_arb #(
  parameter int NREQ   = 2,
  parameter int AW     = 11,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic              mclk,
  input  logic              s_reset_n,
  input  logic [NREQ-1:0]   m_cs,
  input  logic [NREQ-1:0]   m_wr,
  input  logic [NREQ*AW-1:0] m_addr,
  input  logic [NREQ*DW-1:0] m_wdata,
  input  logic [NREQ*4-1:0] m_be,
  output logic [DW-1:0]     m_rdata,
  output logic [NREQ-1:0]   m_ack,
  output logic              m_err,
  output logic              reg_cs,
  output logic              reg_wr,
  output logic [AW-1:0]     reg_addr,
  output logic [DW-1:0]     reg_wdata,
  output logic [3:0]        reg_be,
  input  logic [DW-1:0]     reg_rdata,
  input  logic              reg_ack,
  output logic              arb_busy
);

  import peri_arb_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_st_e         state_reg, state_next;
  logic [IW-1:0]   gnt_reg, gnt_next;
  logic [IW-1:0]   last_gnt_reg, last_gnt_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            reg_cs_reg, reg_cs_next;
  logic            reg_wr_reg, reg_wr_next;
  logic [AW-1:0]   reg_addr_reg, reg_addr_next;
  logic [DW-1:0]   reg_wdata_reg, reg_wdata_next;
  logic [3:0]      reg_be_reg, reg_be_next;
  logic [DW-1:0]   m_rdata_reg, m_rdata_next;
  logic [NREQ-1:0] m_ack_reg, m_ack_next;
  logic            m_err_reg, m_err_next;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic [3:0]      be_arr    [NREQ];
  logic [IW-1:0]   gnt_idx;
  logic            gnt_vld;
  logic            to_expired;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[gi*AW +: AW];
      assign wdata_arr[gi] = m_wdata[gi*DW +: DW];
      assign be_arr[gi]    = m_be[gi*4 +: 4];
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req      (m_cs),
    .last_gnt (last_gnt_reg),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

  assign to_expired = (to_cnt_reg == TO_W'(TO_CYC));

  always_ff @(posedge mclk) begin
    if (!s_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt_vld) state_next = BUSY;
      BUSY:    if (reg_ack || to_expired) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A real ack always takes priority over the timeout on the same cycle.
  always_comb begin
    gnt_next       = gnt_reg;
    last_gnt_next  = last_gnt_reg;
    to_cnt_next    = to_cnt_reg;
    reg_cs_next    = reg_cs_reg;
    reg_wr_next    = reg_wr_reg;
    reg_addr_next  = reg_addr_reg;
    reg_wdata_next = reg_wdata_reg;
    reg_be_next    = reg_be_reg;
    m_rdata_next   = m_rdata_reg;
    m_ack_next     = '0;
    m_err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_vld) begin
          reg_cs_next    = 1'b1;
          reg_wr_next    = m_wr[gnt_idx];
          reg_addr_next  = addr_arr[gnt_idx];
          reg_wdata_next = wdata_arr[gnt_idx];
          reg_be_next    = be_arr[gnt_idx];
          gnt_next       = gnt_idx;
          last_gnt_next  = gnt_idx;
          to_cnt_next    = '0;
        end
      end
      BUSY: begin
        if (reg_ack) begin
          m_rdata_next        = reg_rdata;
          m_ack_next[gnt_reg] = 1'b1;
          reg_cs_next         = 1'b0;
        end else if (to_expired) begin
          m_rdata_next        = DW'(ERR_RDATA);
          m_ack_next[gnt_reg] = 1'b1;
          m_err_next          = 1'b1;
          reg_cs_next         = 1'b0;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!s_reset_n) begin
      gnt_reg       <= '0;
      last_gnt_reg  <= IW'(NREQ - 1);
      to_cnt_reg    <= '0;
      reg_cs_reg    <= 1'b0;
      reg_wr_reg    <= 1'b0;
      reg_addr_reg  <= '0;
      reg_wdata_reg <= '0;
      reg_be_reg    <= '0;
      m_rdata_reg   <= '0;
      m_ack_reg     <= '0;
      m_err_reg     <= 1'b0;
    end else begin
      gnt_reg       <= gnt_next;
      last_gnt_reg  <= last_gnt_next;
      to_cnt_reg    <= to_cnt_next;
      reg_cs_reg    <= reg_cs_next;
      reg_wr_reg    <= reg_wr_next;
      reg_addr_reg  <= reg_addr_next;
      reg_wdata_reg <= reg_wdata_next;
      reg_be_reg    <= reg_be_next;
      m_rdata_reg   <= m_rdata_next;
      m_ack_reg     <= m_ack_next;
      m_err_reg     <= m_err_next;
    end
  end

  assign reg_cs    = reg_cs_reg;
  assign reg_wr    = reg_wr_reg;
  assign reg_addr  = reg_addr_reg;
  assign reg_wdata = reg_wdata_reg;
  assign reg_be    = reg_be_reg;
  assign m_rdata   = m_rdata_reg;
  assign m_ack     = m_ack_reg;
  assign m_err     = m_err_reg;
  assign arb_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_peri_reg_arb.sv
// Randomized bench for peri_reg_arb against a transaction-level reference model.
module tb_peri_reg_arb;

  localparam int NREQ   = 2;
  localparam int AW     = 11;
  localparam int DW     = 32;
  localparam int TO_CYC = 255;

  logic              mclk = 1'b0;
  logic              s_reset_n = 1'b0;
  logic [NREQ-1:0]   m_cs = '0;
  logic [NREQ-1:0]   m_wr = '0;
  logic [NREQ*AW-1:0] m_addr = '0;
  logic [NREQ*DW-1:0] m_wdata = '0;
  logic [NREQ*4-1:0] m_be = '0;
  logic [DW-1:0]     m_rdata;
  logic [NREQ-1:0]   m_ack;
  logic              m_err;
  logic              reg_cs;
  logic              reg_wr;
  logic [AW-1:0]     reg_addr;
  logic [DW-1:0]     reg_wdata;
  logic [3:0]        reg_be;
  logic [DW-1:0]     reg_rdata = '0;
  logic              reg_ack = 1'b0;
  logic              arb_busy;

  peri_reg_arb #(
    .NREQ   (NREQ),
    .AW     (AW),
    .DW     (DW),
    .TO_CYC (TO_CYC)
  ) dut (
    .mclk      (mclk),
    .s_reset_n (s_reset_n),
    .m_cs      (m_cs),
    .m_wr      (m_wr),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_be      (m_be),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .arb_busy  (arb_busy)
  );

  always #5 mclk = ~mclk;

  // Reference model: who owns the bus, how long it has waited, and stimulus policy.
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int cur = -1;
  int last = NREQ - 1;
  int busy = 0;
  int delay = 0;
  bit resp = 1'b0;
  int n_txn = 0;
  int req_mode = 0;
  int delay_mode = -2;
  int spur_mode = 0;
  bit drop_en = 1'b0;
  bit fix_rd = 1'b0;
  logic [DW-1:0] fix_rdata = '0;
  logic          g_wr;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic [3:0]    g_be;
  logic [NREQ-1:0] done_mask = '0;
  int obs_gnt[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick(input int lst, input logic [NREQ-1:0] cs);
    for (int k = 1; k <= NREQ; k++) begin
      if (cs[(lst + k) % NREQ]) return (lst + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
    m_wr[i]            = wr;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
    m_be[i*4 +: 4]     = be;
    m_cs[i]            = 1'b1;
  endtask

  task automatic rand_req(input int i);
    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom));
  endtask

  task automatic finish_txn(input bit err);
    int obs = -1;
    for (int i = 0; i < NREQ; i++) if (m_ack[i]) obs = i;
    obs_gnt.push_back(obs);
    $display("txn %0d m%0d wr=%0d addr=%h err=%0d rdata=%h", n_txn, cur, g_wr, g_addr, err, m_rdata);
    done_mask[cur] = 1'b1;
    cur = -1;
    resp = 1'b1;
    n_txn++;
  endtask

  task automatic drive_next();
    for (int i = 0; i < NREQ; i++) begin
      if (done_mask[i]) begin
        m_cs[i] = 1'b0;
        if (req_mode == 2 || (req_mode == 1 && $urandom_range(0, 1) == 0)) rand_req(i);
      end else if (!m_cs[i] && i != cur && req_mode == 1 && $urandom_range(0, 3) == 0) begin
        rand_req(i);
      end
    end
    done_mask = '0;
    if (drop_en && cur >= 0 && $urandom_range(0, 15) == 0) m_cs[cur] = 1'b0;
    reg_ack = 1'b0;
    if (cur >= 0) begin
      if (delay >= 0 && busy == delay) reg_ack = 1'b1;
    end else if (spur_mode == 1 || (spur_mode == 2 && $urandom_range(0, 3) == 0)) begin
      reg_ack = 1'b1;
    end
    reg_rdata = fix_rd ? fix_rdata : $urandom;
  endtask

  task automatic step();
    logic [NREQ-1:0] cs_in;
    logic [NREQ-1:0] exp_ack;
    logic            ack_in;
    logic [DW-1:0]   rd_in;
    logic            rst_in;
    int              g;
    cs_in  = m_cs;
    ack_in = reg_ack;
    rd_in  = reg_rdata;
    rst_in = s_reset_n;
    @(posedge mclk);
    #1;
    cyc++;
    exp_ack = '0;
    if (!rst_in) begin
      check_val("rst_reg_cs", 32'(reg_cs), 32'd0);
      check_val("rst_reg_wr", 32'(reg_wr), 32'd0);
      check_val("rst_reg_addr", 32'(reg_addr), 32'd0);
      check_val("rst_reg_wdata", reg_wdata, 32'd0);
      check_val("rst_reg_be", 32'(reg_be), 32'd0);
      check_val("rst_m_ack", 32'(m_ack), 32'd0);
      check_val("rst_m_err", 32'(m_err), 32'd0);
      check_val("rst_m_rdata", m_rdata, 32'd0);
      check_val("rst_busy", 32'(arb_busy), 32'd0);
      cur = -1; resp = 1'b0; last = NREQ - 1; busy = 0;
    end else if (resp) begin
      check_val("resp_ack", 32'(m_ack), 32'd0);
      check_val("resp_err", 32'(m_err), 32'd0);
      check_val("resp_cs", 32'(reg_cs), 32'd0);
      check_val("resp_busy", 32'(arb_busy), 32'd0);
      resp = 1'b0;
    end else if (cur < 0) begin
      if (cs_in != '0) begin
        g = rr_pick(last, cs_in);
        g_wr = m_wr[g]; g_addr = m_addr[g*AW +: AW];
        g_wdata = m_wdata[g*DW +: DW]; g_be = m_be[g*4 +: 4];
        check_val("gnt_cs", 32'(reg_cs), 32'd1);
        check_val("gnt_wr", 32'(reg_wr), 32'(g_wr));
        check_val("gnt_addr", 32'(reg_addr), 32'(g_addr));
        check_val("gnt_wdata", reg_wdata, g_wdata);
        check_val("gnt_be", 32'(reg_be), 32'(g_be));
        check_val("gnt_ack", 32'(m_ack), 32'd0);
        check_val("gnt_busy", 32'(arb_busy), 32'd1);
        cur = g; last = g; busy = 0;
        delay = (delay_mode == -2) ? int'($urandom_range(0, 4)) : delay_mode;
      end else begin
        check_val("idle_cs", 32'(reg_cs), 32'd0);
        check_val("idle_ack", 32'(m_ack), 32'd0);
        check_val("idle_busy", 32'(arb_busy), 32'd0);
      end
    end else if (ack_in) begin
      exp_ack[cur] = 1'b1;
      check_val("ack_vec", 32'(m_ack), 32'(exp_ack));
      check_val("ack_err", 32'(m_err), 32'd0);
      check_val("ack_rdata", m_rdata, rd_in);
      check_val("ack_cs_drop", 32'(reg_cs), 32'd0);
      check_val("ack_busy", 32'(arb_busy), 32'd1);
      finish_txn(1'b0);
    end else if (busy == TO_CYC) begin
      exp_ack[cur] = 1'b1;
      check_val("to_vec", 32'(m_ack), 32'(exp_ack));
      check_val("to_err", 32'(m_err), 32'd1);
      check_val("to_rdata", m_rdata, 32'hFFFF_FFFF);
      check_val("to_cs_drop", 32'(reg_cs), 32'd0);
      finish_txn(1'b1);
    end else begin
      check_val("busy_ack", 32'(m_ack), 32'd0);
      check_val("busy_cs", 32'(reg_cs), 32'd1);
      check_val("busy_addr", 32'(reg_addr), 32'(g_addr));
      check_val("busy_wdata", reg_wdata, g_wdata);
      check_val("busy_busy", 32'(arb_busy), 32'd1);
      busy++;
    end
    drive_next();
  endtask

  task automatic run_txns(input int n, input int max_cyc);
    int target;
    int k;
    target = n_txn + n;
    k = 0;
    while (n_txn < target && k < max_cyc) begin
      step();
      k++;
    end
    check_val("txn_bound", 32'(n_txn >= target), 32'd1);
  endtask

  task automatic run_idle(input int max_cyc);
    int k;
    k = 0;
    while (!(m_cs == '0 && cur < 0 && !resp) && k < max_cyc) begin
      step();
      k++;
    end
    check_val("idle_bound", 32'(k < max_cyc), 32'd1);
  endtask

  initial begin
    int k;
    // reset
    s_reset_n = 1'b0;
    step();
    step();
    s_reset_n = 1'b1;
    step();

    // single read from master 0, ack two cycles after reg_cs
    fix_rd = 1'b1; fix_rdata = 32'h1234_5678; delay_mode = 2;
    set_req(0, 1'b0, 11'h080, 32'h0, 4'hF);
    run_txns(1, 20);
    check_val("t1_rdata", m_rdata, 32'h1234_5678);
    check_val("t1_ack", 32'(m_ack), 32'h1);
    fix_rd = 1'b0;
    run_idle(10);

    // both masters contend continuously; grants must alternate
    delay_mode = -2; req_mode = 2;
    obs_gnt.delete();
    rand_req(0);
    rand_req(1);
    run_txns(8, 100);
    for (int i = 1; i < obs_gnt.size(); i++)
      check_val("t2_alt", 32'(obs_gnt[i]), 32'(1 - obs_gnt[i-1]));
    req_mode = 0;
    run_idle(100);

    // write from master 1 never acknowledged -> timeout
    delay_mode = -1;
    set_req(1, 1'b1, 11'h155, 32'hA5A5_0000, 4'b0011);
    run_txns(1, 300);
    check_val("t3_ack", 32'(m_ack), 32'h2);
    check_val("t3_err", 32'(m_err), 32'd1);
    check_val("t3_rdata", m_rdata, 32'hFFFF_FFFF);
    run_idle(10);

    // ack lands on the very cycle the timeout would fire
    delay_mode = TO_CYC; fix_rd = 1'b1; fix_rdata = 32'hCAFE_0001;
    set_req(0, 1'b0, 11'h2AA, 32'h0, 4'hF);
    run_txns(1, 300);
    check_val("t4_err", 32'(m_err), 32'd0);
    check_val("t4_rdata", m_rdata, 32'hCAFE_0001);
    fix_rd = 1'b0;
    run_idle(10);

    // reset in the middle of a long transaction; master 0 must win afterwards
    delay_mode = 40;
    set_req(0, 1'b0, 11'h011, 32'h0, 4'hF);
    set_req(1, 1'b1, 11'h722, 32'h5555_AAAA, 4'hC);
    k = 0;
    while (cur < 0 && k < 10) begin step(); k++; end
    check_val("t5_pre_bound", 32'(k < 10), 32'd1);
    step();
    step();
    s_reset_n = 1'b0;
    step();
    s_reset_n = 1'b1;
    k = 0;
    while (cur < 0 && k < 10) begin step(); k++; end
    check_val("t5_post_bound", 32'(k < 10), 32'd1);
    check_val("t5_first_gnt", 32'(reg_addr), 32'(11'h011));
    delay_mode = -2;
    run_idle(200);

    // stray acks with no requester are ignored
    spur_mode = 1;
    repeat (6) step();
    spur_mode = 0;

    // random traffic with drops and stray acks
    req_mode = 1; delay_mode = -2; drop_en = 1'b1; spur_mode = 2;
    run_txns(40, 3000);
    req_mode = 0; drop_en = 1'b0; spur_mode = 0;
    run_idle(200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
